// File: rtl/ddr_pixel_stream_tx_if.sv
// rtl/ddr_pixel_stream_tx_if.sv - AXI-Stream style pixel beat bundle
// Purpose: carries one packed nine-direction pixel per beat.
// Signals: tdata (9*DATA_WIDTH), tstrb (byte strobes), tvalid, tlast, tready.
// Modports: master drives data/valid/last and samples ready; slave is the mirror.
interface ddr_pixel_stream_tx_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic [9*DATA_WIDTH-1:0]   tdata;
    logic [9*DATA_WIDTH/8-1:0] tstrb;
    logic                      tvalid;
    logic                      tlast;
    logic                      tready;

    modport master (
        output tdata,
        output tstrb,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tstrb,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/ddr_pixel_stream_tx.sv
// rtl/ddr_pixel_stream_tx.sv - streams one frame of lattice BRAM pixels out as AXI-Stream beats
// Purpose: on start, reads addresses 0..DEPTH-1 from a one-cycle-latency BRAM,
//          buffers the nine direction words in a 2-entry FIFO and emits one
//          packed beat per pixel, tlast on the final pixel, then pulses done.
// Ports:
//   m00_axis_aclk      sole clock, rising edge
//   m00_axis_aresetn   asynchronous active-low reset
//   start              frame request, only sampled while idle
//   read_addr, ren     BRAM read address / read enable (data valid next cycle)
//   n1..nw1            BRAM read data for the nine directions
//   m00_axis           stream master (tdata/tstrb/tvalid/tlast out, tready in)
//   busy, done         frame in progress / one-cycle completion pulse
//   frame_count        completed-frame counter, only when PIXEL_TX_FRAME_COUNT_EN is defined
// Optional feature macro: PIXEL_TX_FRAME_COUNT_EN
module ddr_pixel_stream_tx #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 2500,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     m00_axis_aclk,
    input  logic                     m00_axis_aresetn,
    input  logic                     start,
    output logic [ADDRESS_WIDTH-1:0] read_addr,
    output logic                     ren,
    input  logic [DATA_WIDTH-1:0]    n1,
    input  logic [DATA_WIDTH-1:0]    null1,
    input  logic [DATA_WIDTH-1:0]    ne1,
    input  logic [DATA_WIDTH-1:0]    e1,
    input  logic [DATA_WIDTH-1:0]    se1,
    input  logic [DATA_WIDTH-1:0]    s1,
    input  logic [DATA_WIDTH-1:0]    sw1,
    input  logic [DATA_WIDTH-1:0]    w1,
    input  logic [DATA_WIDTH-1:0]    nw1,
    output logic                     busy,
    output logic                     done,
    ddr_pixel_stream_tx_if.master    m00_axis
`ifdef PIXEL_TX_FRAME_COUNT_EN
    ,
    output logic [15:0]              frame_count
`endif
);

    localparam int BEAT_W = 9 * DATA_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [ADDRESS_WIDTH-1:0] r_beat;
    logic                     r_inflight;
    logic [BEAT_W-1:0]        r_fifo [2];
    logic                     r_wr_ptr;
    logic                     r_rd_ptr;
    logic [1:0]               r_count;
    logic                     r_done;

    logic                     w_ren;
    logic                     w_tvalid;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_last_beat;
    logic                     w_enter_idle;
    logic [2:0]               w_occupancy;
    logic                     w_room;
    logic [BEAT_W-1:0]        w_pixel;

    assign w_pixel = {nw1, w1, sw1, s1, se1, e1, ne1, null1, n1};

    assign w_tvalid    = (r_count != 2'd0);
    assign w_pop       = w_tvalid && m00_axis.tready;
    assign w_push      = r_inflight;
    assign w_last_beat = (r_beat == LAST_IDX);

    // A read may only be issued if its data is guaranteed a FIFO slot when it
    // lands next cycle: queued + in-flight, less the beat leaving now, must be < 2.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_room      = (w_occupancy < (3'd2 + {2'b00, w_pop}));

    assign w_enter_idle = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ren       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                w_ren = w_room;
                if (w_ren && (r_addr == LAST_IDX)) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_pop && w_last_beat) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            r_addr     <= '0;
            r_beat     <= '0;
            r_inflight <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_ren;
            r_done     <= w_pop && w_last_beat;

            // Counters stop at the last index rather than wrapping; both are
            // cleared when the frame completes.
            if (w_enter_idle) begin
                r_addr <= '0;
                r_beat <= '0;
            end else begin
                if (w_ren && (r_addr != LAST_IDX)) begin
                    r_addr <= r_addr + 1'b1;
                end
                if (w_pop && !w_last_beat) begin
                    r_beat <= r_beat + 1'b1;
                end
            end

            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_pixel;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign ren       = w_ren;
    assign read_addr = r_addr;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

    assign m00_axis.tvalid = w_tvalid;
    assign m00_axis.tdata  = r_fifo[r_rd_ptr];
    assign m00_axis.tstrb  = '1;
    assign m00_axis.tlast  = w_tvalid && w_last_beat;

`ifdef PIXEL_TX_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    // Advances on the same edge that raises done, wrapping naturally at 65535.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            r_frame_count <= 16'd0;
        end else if (w_pop && w_last_beat) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

endmodule

// File: doc/ddr_pixel_stream_tx.md
DDR_PIXEL_STREAM_TX -- requirements
Module: ddr_pixel_stream_tx

Interface
- REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the width of one direction value.
- REQ-002 Parameter DEPTH, default 2500, SHALL set the pixels per frame.
- REQ-003 Parameter ADDRESS_WIDTH, default 12, SHALL set the read address width.
- REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
- REQ-005 m00_axis_aclk  in  1  sole clock, rising edge.
- REQ-006 m00_axis_aresetn  in  1  asynchronous active-low reset.
- REQ-007 start  in  1  frame request, sampled in IDLE only.
- REQ-008 read_addr  out  ADDRESS_WIDTH  lattice BRAM pixel read address.
- REQ-009 ren  out  1  BRAM read enable; data valid exactly one cycle after ren.
- REQ-010 n1, null1, ne1, e1, se1, s1, sw1, w1, nw1  in  DATA_WIDTH each  BRAM read data, the nine directions.
- REQ-011 m00_axis_tvalid, m00_axis_tlast  out  1 each; m00_axis_tdata  out  144; m00_axis_tstrb  out  18; m00_axis_tready  in  1.
- REQ-012 busy  out  1  high from start acceptance until the last beat is accepted; done  out  1  single-cycle completion pulse.

Function
- REQ-013 FSM states SHALL be IDLE, STREAM and FLUSH; IDLE->STREAM on start; STREAM->FLUSH after the read of address DEPTH-1 is issued; FLUSH->IDLE when the tlast beat is accepted.
- REQ-014 start SHALL be ignored outside IDLE.
- REQ-015 In STREAM, ren SHALL be asserted only when (fifo_count + inflight - pop) < 2, where pop = tvalid && tready; read_addr SHALL run 0..DEPTH-1, incrementing after each ren.
- REQ-016 A 2-entry output FIFO SHALL capture BRAM data in the cycle after ren; it SHALL never overflow, and a simultaneous push and pop SHALL leave the count unchanged.
- REQ-017 tdata SHALL pack n1 into [15:0], null1 [31:16], ne1 [47:32], e1 [63:48], se1 [79:64], s1 [95:80], sw1 [111:96], w1 [127:112], nw1 [143:128]; tstrb SHALL be all ones.
- REQ-018 tvalid SHALL equal FIFO non-empty; once asserted, tvalid and tdata SHALL hold stable until accepted.
- REQ-019 tlast SHALL be high only with the beat whose output index equals DEPTH-1.
- REQ-020 Latency: start sampled at edge k -> ren for address 0 in the following cycle -> first tvalid after edge k+2.
- REQ-021 With tready held high, one beat per cycle SHALL be sustained.
- REQ-022 tready low SHALL stall reads within one cycle with no loss or duplication.
- REQ-023 done SHALL pulse in the cycle after the tlast handshake; busy SHALL fall at the same edge.
- REQ-024 The address counter and output-beat counter SHALL NOT wrap within a frame; both SHALL clear on IDLE entry.

Reset
- REQ-025 While m00_axis_aresetn is low: state=IDLE; read_addr=0; ren=0; tvalid=0; tlast=0; tdata=0; busy=0; done=0; FIFO and inflight cleared.
- REQ-026 Reset asserted mid-frame SHALL deassert tvalid immediately; the frame SHALL be abandoned with no done pulse.

Configuration
- REQ-027 With macro PIXEL_TX_FRAME_COUNT_EN defined, a 16-bit output frame_count SHALL reset to 0, increment on each done pulse, and wrap 65535->0.
- REQ-028 Without PIXEL_TX_FRAME_COUNT_EN, the frame_count port and its logic SHALL be absent.

Verification (DEPTH=4 override unless stated)
- REQ-029 Start pulse, tready=1, BRAM word = 16'h0A00+addr per direction -> 4 consecutive beats, tdata[15:0]=0A00..0A03, tlast on beat 4 only, done one cycle later.
- REQ-030 tready toggling 1010... -> exactly 4 beats, in order, no duplicates, tdata stable while tvalid && !tready.
- REQ-031 tready=0 for 10 cycles after start -> ren stops after 2 reads; tvalid held with addr 0 data; resuming yields all 4 beats.
- REQ-032 start pulsed again during STREAM -> ignored; a single 4-beat frame, one done.
- REQ-033 Reset asserted after beat 2 -> tvalid=0 the same cycle; a new start yields beats from addr 0 with correct tlast.
- REQ-034 Default DEPTH=2500, PIXEL_TX_FRAME_COUNT_EN defined, two frames -> 2500 beats each, tlast at index 2499, frame_count=2.
